// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter in front of a single-port memory
module mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out
);
  typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;
  state_t state_q, state_d;
  logic last_gnt_q, last_gnt_d;
  logic gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic busy_q, busy_d, read_q, read_d, write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_in_q, data_in_d, rdata_q, rdata_d;
  logic win, win_we;
  // next state: arbitrate and capture in IDLE, strobe in ACCESS, return read data from RDATA
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    read_d     = 1'b0;
    write_d    = 1'b0;
    addr_d     = addr_q;
    data_in_d  = data_in_q;
    rdata_d    = rdata_q;
    win        = req1 & ~(req0 & last_gnt_q);
    win_we     = win ? we1 : we0;
    unique case (state_q)
      IDLE: if (req0 | req1) begin
        state_d    = ACCESS;
        last_gnt_d = win;
        gnt0_d     = ~win;
        gnt1_d     = win;
        write_d    = win_we;
        read_d     = ~win_we;
        addr_d     = win ? addr1 : addr0;
        data_in_d  = win_we ? (win ? wdata1 : wdata0) : '0;
      end
      ACCESS: state_d = write_q ? IDLE : RDATA;
      RDATA: begin
        state_d   = IDLE;
        rdata_d   = data_out;
        rvalid0_d = ~last_gnt_q;
        rvalid1_d = last_gnt_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  // state and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      busy_q     <= 1'b0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      data_in_q  <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      busy_q     <= busy_d;
      read_q     <= read_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      data_in_q  <= data_in_d;
      rdata_q    <= rdata_d;
    end
  end
  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign busy    = busy_q;
  assign read    = read_q;
  assign write   = write_q;
  assign addr    = addr_q;
  assign data_in = data_in_q;
  assign rdata   = rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors, corner sequences and random traffic against a timeline model
module tb_mem_arbiter;
  logic clk = 0;
  logic rst_ = 0;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [4:0] addr0 = 0, addr1 = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0;
  logic gnt0, gnt1, rvalid0, rvalid1, busy, read, write;
  logic [7:0] rdata, data_in;
  logic [7:0] data_out = 0;
  logic [4:0] addr;
  logic [7:0] env_mem [32];
  logic [7:0] ref_mem [32];
  int n_asrt = 0, n_fail = 0;
  int n_edge = 0, free_edge = 0, rv_edge = -1;
  logic rv_who = 0, last = 1, chk_ad = 0;
  logic [7:0] rv_data = 0;
  logic e_gnt0, e_gnt1, e_rd, e_wr, e_busy, e_rv0, e_rv1;
  logic [4:0] e_addr = 0;
  logic [7:0] e_din = 0, e_rdata = 0;

  mem_arbiter #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk(clk), .rst_(rst_), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .busy(busy), .read(read), .write(write), .addr(addr), .data_in(data_in), .data_out(data_out)
  );

  always #5 clk = ~clk;

  // external memory: write commits on the edge ending a write cycle, read data valid the cycle after read
  always @(posedge clk) begin
    if (write) env_mem[addr] <= data_in;
    if (read) data_out <= env_mem[addr];
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_asrt++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, got, exp, n_edge);
    end
  endtask

  // advance one clock; the model predicts from the request timeline, then outputs are compared
  task automatic tick();
    logic w, wwe;
    logic [4:0] wa;
    logic [7:0] wd;
    @(posedge clk);
    n_edge++;
    {e_gnt0, e_gnt1, e_rd, e_wr, e_rv0, e_rv1} = '0;
    chk_ad = 0;
    if (!rst_) begin
      free_edge = n_edge + 1;
      rv_edge = -1;
      last = 1;
      e_rdata = 0;
      e_addr = 0;
      e_din = 0;
      e_busy = 0;
      chk_ad = 1;
    end else begin
      if (n_edge == rv_edge) begin
        e_rv0 = !rv_who;
        e_rv1 = rv_who;
        e_rdata = rv_data;
      end
      if (n_edge >= free_edge && (req0 || req1)) begin
        w = (req0 && req1) ? !last : req1;
        last = w;
        wwe = w ? we1 : we0;
        wa = w ? addr1 : addr0;
        wd = w ? wdata1 : wdata0;
        e_gnt0 = !w;
        e_gnt1 = w;
        e_wr = wwe;
        e_rd = !wwe;
        e_addr = wa;
        e_din = wwe ? wd : 8'h00;
        chk_ad = 1;
        if (wwe) begin
          ref_mem[wa] = wd;
          free_edge = n_edge + 2;
        end else begin
          rv_edge = n_edge + 2;
          rv_who = w;
          rv_data = ref_mem[wa];
          free_edge = n_edge + 3;
        end
      end
      e_busy = n_edge < free_edge - 1;
    end
    #1;
    check("outputs", {gnt0, gnt1, read, write, busy, rvalid0, rvalid1, rdata},
          {e_gnt0, e_gnt1, e_rd, e_wr, e_busy, e_rv0, e_rv1, e_rdata});
    if (chk_ad) check("addr_data_in", {addr, data_in}, {e_addr, e_din});
    check("rd_wr_excl", read & write, 1'b0);
    check("gnt_onehot", gnt0 & gnt1, 1'b0);
    check("rvalid_onehot", rvalid0 & rvalid1, 1'b0);
  endtask

  // issue one access from requester `who`, holding it until granted, then run to completion
  task automatic do_access(input logic who, input logic we, input logic [4:0] a, input logic [7:0] d,
                           output logic got_rv, output logic [7:0] got_rd);
    logic ok = 0;
    if (who) begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
    else begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    for (int k = 0; k < 10 && !ok; k++) begin
      tick();
      ok = who ? gnt1 : gnt0;
    end
    n_asrt++;
    if (!ok) begin
      n_fail++;
      $display("FAIL gnt_timeout: requester %0d not granted within 10 cycles", who);
    end
    req0 = 0;
    req1 = 0;
    tick();
    if (!we) tick();
    got_rv = who ? rvalid1 : rvalid0;
    got_rd = rdata;
  endtask

  typedef struct {
    logic rstn, r0, w0, r1, w1;
    logic [4:0] a;
    logic [7:0] d;
    logic [6:0] fl;
    logic [4:0] ea;
    logic [7:0] ed, er;
  } vec_t;
  vec_t tbl [11];

  initial begin
    logic rv;
    logic [7:0] rd;
    int g0, g1;
    logic a0, a1;
    // flags: gnt0 gnt1 read write busy rvalid0 rvalid1
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 8'h00, 7'b0000000, 5'h00, 8'h00, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'h03, 8'hA5, 7'b1001100, 5'h03, 8'hA5, 8'h00};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 8'h00, 7'b0000000, 5'h00, 8'h00, 8'h00};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'h03, 8'h00, 7'b0110100, 5'h03, 8'h00, 8'h00};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 8'h00, 7'b0000100, 5'h00, 8'h00, 8'h00};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 8'h00, 7'b0000001, 5'h00, 8'h00, 8'hA5};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 8'h00, 7'b0000000, 5'h00, 8'h00, 8'hA5};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'h07, 8'h3C, 7'b1001100, 5'h07, 8'h3C, 8'hA5};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'h07, 8'h3C, 7'b0000000, 5'h00, 8'h00, 8'hA5};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'h07, 8'h3C, 7'b0101100, 5'h07, 8'h3C, 8'hA5};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 8'h00, 7'b0000000, 5'h00, 8'h00, 8'hA5};
    for (int i = 0; i < 11; i++) begin
      rst_ = tbl[i].rstn;
      req0 = tbl[i].r0; we0 = tbl[i].w0; addr0 = tbl[i].a; wdata0 = tbl[i].d;
      req1 = tbl[i].r1; we1 = tbl[i].w1; addr1 = tbl[i].a; wdata1 = tbl[i].d;
      tick();
      check($sformatf("vec%0d_flags", i), {gnt0, gnt1, read, write, busy, rvalid0, rvalid1}, tbl[i].fl);
      check($sformatf("vec%0d_rdata", i), rdata, tbl[i].er);
      if (tbl[i].fl[4] || tbl[i].fl[3] || !tbl[i].rstn)
        check($sformatf("vec%0d_addr_din", i), {addr, data_in}, {tbl[i].ea, tbl[i].ed});
    end

    // both requesters held high with writes: alternate grants starting with requester 0
    rst_ = 0;
    tick();
    rst_ = 1;
    req0 = 1; we0 = 1; addr0 = 5'h0A; wdata0 = 8'h11;
    req1 = 1; we1 = 1; addr1 = 5'h15; wdata1 = 8'h22;
    g0 = 0;
    g1 = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 0) check("first_contention", {gnt0, gnt1}, 2'b10);
      g0 += int'(gnt0);
      g1 += int'(gnt1);
    end
    check("contention_gnt0_count", g0, 3);
    check("contention_gnt1_count", g1, 2);
    req0 = 0;
    req1 = 0;
    tick();
    tick();

    // clear sweep, then data = address sweep, reads alternating between requesters
    for (int i = 0; i < 32; i++) do_access(1'(i), 1'b1, 5'(i), 8'h00, rv, rd);
    for (int i = 0; i < 32; i++) begin
      do_access(1'(i + 1), 1'b0, 5'(i), 8'h00, rv, rd);
      check($sformatf("clear_rd_%0d", i), {rv, rd}, {1'b1, 8'h00});
    end
    for (int i = 0; i < 32; i++) do_access(1'(i + 1), 1'b1, 5'(i), 8'(i), rv, rd);
    for (int i = 0; i < 32; i++) begin
      do_access(1'(i), 1'b0, 5'(i), 8'h00, rv, rd);
      check($sformatf("sweep_rd_%0d", i), {rv, rd}, {1'b1, 8'(i)});
    end

    // reset landing on the closing edge of RDATA: no rvalid, everything cleared
    req0 = 1; we0 = 0; addr0 = 5'h05;
    tick();
    check("rst_rd_gnt", gnt0, 1'b1);
    req0 = 0;
    tick();
    check("rst_rd_in_rdata", {busy, read}, 2'b10);
    rst_ = 0;
    tick();
    check("rst_rd_outputs", {gnt0, gnt1, rvalid0, rvalid1, read, write, busy, addr, data_in, rdata}, 0);
    rst_ = 1;
    tick();
    check("rst_rd_no_late_rv", {rvalid0, rvalid1}, 2'b00);
    do_access(1'b0, 1'b0, 5'h05, 8'h00, rv, rd);
    check("post_rst_read", {rv, rd}, {1'b1, 8'h05});

    // reset during ACCESS of a read
    req1 = 1; we1 = 0; addr1 = 5'h1F;
    tick();
    check("rst_acc_gnt", gnt1, 1'b1);
    req1 = 0;
    rst_ = 0;
    tick();
    check("rst_acc_outputs", {gnt0, gnt1, rvalid0, rvalid1, read, write, busy, addr, data_in, rdata}, 0);
    rst_ = 1;
    tick();
    tick();
    check("rst_acc_no_rv", {rvalid0, rvalid1}, 2'b00);
    do_access(1'b1, 1'b0, 5'h1F, 8'h00, rv, rd);
    check("read_1f", {rv, rd}, {1'b1, 8'h1F});

    // random traffic with occasional resets, checked cycle by cycle against the model
    a0 = 0;
    a1 = 0;
    for (int k = 0; k < 2000; k++) begin
      if (!a0 && $urandom_range(2) == 0) begin
        a0 = 1; we0 = 1'($urandom); addr0 = 5'($urandom); wdata0 = 8'($urandom);
      end
      if (!a1 && $urandom_range(2) == 0) begin
        a1 = 1; we1 = 1'($urandom); addr1 = 5'($urandom); wdata1 = 8'($urandom);
      end
      req0 = a0;
      req1 = a1;
      rst_ = $urandom_range(99) != 0;
      tick();
      if (e_gnt0) a0 = 0;
      if (e_gnt1) a1 = 0;
    end
    rst_ = 1;
    req0 = 0;
    req1 = 0;
    tick();
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
